stopwatch_counter: RTL and testbench
====================================

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clk cycles per counted second (minimum 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port key_start_n  input  1  start/stop pushbutton, asynchronous, active-low.
REQ-005 SHALL have port key_clear_n  input  1  clear pushbutton, asynchronous, active-low.
REQ-006 SHALL have port sec_out  output  8  seconds count, binary 0-59, upper bits zero; feeds the binary-to-BCD stage.
REQ-007 SHALL have port min_out  output  8  minutes count, binary 0-59, upper bits zero; feeds the binary-to-BCD stage.
REQ-008 SHALL have port running  output  1  high while in state RUN.
REQ-009 SHALL have port rollover  output  1  one-cycle pulse on 59:59 -> 00:00 wrap.

Function
REQ-010 SHALL pass each key through a 2-flop synchronizer, then a falling-edge detector, giving a one-cycle internal pulse (start_p, clear_p) on the 3rd rising edge after the key is first sampled low.
REQ-011 SHALL emit a single pulse per press; a held key SHALL NOT repeat.
REQ-012 SHALL implement states IDLE, RUN, PAUSE: IDLE+start_p -> RUN; RUN+start_p -> PAUSE; PAUSE+start_p -> RUN.
REQ-013 SHALL, on clear_p in any state, go to IDLE and zero prescaler, sec_out, min_out on the next edge.
REQ-014 SHALL give clear_p priority over start_p in the same cycle.
REQ-015 SHALL advance a prescaler 0..TICK_DIV-1 only in RUN, producing an internal tick when it equals TICK_DIV-1 and wrapping it to 0.
REQ-016 SHALL hold the prescaler value in PAUSE, so a resume does not lose the partial second.
REQ-017 SHALL increment sec_out on the edge where tick is high; at 59 it wraps to 0 and min_out increments.
REQ-018 SHALL, at 59:59 plus tick, set both counts to 0 and assert rollover for exactly that one following cycle; counting continues in RUN.
REQ-019 SHALL size the prescaler as $clog2(TICK_DIV) bits.
REQ-020 SHALL register sec_out and min_out directly, with no combinational path from the keys.

Reset
REQ-021 SHALL, with rst_n low at a rising edge, force state IDLE, prescaler 0, sec_out 0, min_out 0, running 0, rollover 0, synchronizer and edge flops to the released value 1.
REQ-022 SHALL let reset mid-count override every other event, and SHALL NOT generate a start or clear pulse on reset release when the keys are idle-high.

Configuration
REQ-023 SHALL, with macro STOPWATCH_LAP_EN defined, add port key_lap_n (input, 1, asynchronous, active-low, synchronized as in REQ-010) and output lap_hold (1).
- First lap pulse in RUN captures the counts and sets lap_hold=1; sec_out/min_out then show the captured value while internal counting continues.
- Next lap pulse clears lap_hold and the outputs show live counts.
- clear_p or reset clears lap_hold.
- Lap pulses outside RUN are ignored.
REQ-024 SHALL, without STOPWATCH_LAP_EN, omit those ports and logic; outputs always show live counts.

Structure
REQ-025 SHALL place the state enum (IDLE, RUN, PAUSE) and constants SEC_MAX=59 and MIN_MAX=59 in shared package stopwatch_pkg.
REQ-026 SHALL implement the synchronizer plus edge detector as sub-module key_edge_sync, instanced once per key.

Verification (TICK_DIV=4)
REQ-027 SHALL cover: reset, start press, 12 cycles -> running=1, sec_out=3, min_out=0.
REQ-028 SHALL cover: run to 00:59, one more tick -> sec_out=0, min_out=1; from 59:59, one tick -> 00:00 with rollover high exactly 1 cycle.
REQ-029 SHALL cover: start at prescaler=2, press start (PAUSE), wait 40 cycles, press start -> counts unchanged during pause; next tick 2 cycles after resume.
REQ-030 SHALL cover: start and clear pressed on the same sample edge -> state IDLE, counts 0, running=0.
REQ-031 SHALL cover: start key held low for 100 cycles -> exactly one state change; rst_n low for one edge mid-count at 07:31 -> 00:00, IDLE.
REQ-032 SHALL cover, with STOPWATCH_LAP_EN: lap at 00:05, run 8 cycles -> outputs stay 00:05; second lap -> outputs 00:07.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch.
// Holds the run-state enum, the count limits and the next-state helper.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd59;

  // Clear always wins over start/stop when both pulses land together.
  function automatic sw_state_t sw_next_state(input sw_state_t cur,
                                              input logic start_p,
                                              input logic clear_p);
    sw_state_t nxt;
    nxt = cur;
    if (clear_p) begin
      nxt = IDLE;
    end else if (start_p) begin
      case (cur)
        IDLE:    nxt = RUN;
        RUN:     nxt = PAUSE;
        PAUSE:   nxt = RUN;
        default: nxt = IDLE;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer plus falling-edge detector for one active-low key.
// Pulse is high for one cycle and is acted on at the 3rd edge after the key is first sampled low.
module key_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  // All flops reset to the released level so reset release never looks like a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign pulse = prev_reg & ~sync2_reg;

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch with start/stop and clear keys, prescaled from clk by TICK_DIV.
// Optional lap-hold display is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start_n,
  input  logic       key_clear_n,
`ifdef STOPWATCH_LAP_EN
  input  logic       key_lap_n,
  output logic       lap_hold,
`endif
  output logic [7:0] sec_out,
  output logic [7:0] min_out,
  output logic       running,
  output logic       rollover
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  logic start_p;
  logic clear_p;

  sw_state_t     state_reg;
  sw_state_t     state_next;
  logic [PW-1:0] presc_reg;
  logic [7:0]    sec_reg;
  logic [7:0]    min_reg;
  logic          rollover_reg;
  logic          tick;

  key_edge_sync u_start_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_start_n),
    .pulse (start_p)
  );

  key_edge_sync u_clear_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_clear_n),
    .pulse (clear_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    state_next = sw_next_state(state_reg, start_p, clear_p);
  end

  assign tick = (state_reg == RUN) && (presc_reg == PRESC_LAST);

  // Prescaler only moves in RUN, so a pause keeps the partial second.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_reg    <= '0;
      sec_reg      <= 8'd0;
      min_reg      <= 8'd0;
      rollover_reg <= 1'b0;
    end else if (clear_p) begin
      presc_reg    <= '0;
      sec_reg      <= 8'd0;
      min_reg      <= 8'd0;
      rollover_reg <= 1'b0;
    end else begin
      rollover_reg <= 1'b0;
      if (state_reg == RUN) begin
        if (tick) begin
          presc_reg <= '0;
          if (sec_reg == SEC_MAX) begin
            sec_reg <= 8'd0;
            if (min_reg == MIN_MAX) begin
              min_reg      <= 8'd0;
              rollover_reg <= 1'b1;
            end else begin
              min_reg <= min_reg + 8'd1;
            end
          end else begin
            sec_reg <= sec_reg + 8'd1;
          end
        end else begin
          presc_reg <= presc_reg + PRESC_ONE;
        end
      end
    end
  end

  assign running  = (state_reg == RUN);
  assign rollover = rollover_reg;

`ifdef STOPWATCH_LAP_EN
  logic       lap_p;
  logic       lap_hold_reg;
  logic [7:0] lap_sec_reg;
  logic [7:0] lap_min_reg;

  key_edge_sync u_lap_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_lap_n),
    .pulse (lap_p)
  );

  // Lap toggles a frozen snapshot of the pre-edge counts; only honoured while running.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lap_hold_reg <= 1'b0;
      lap_sec_reg  <= 8'd0;
      lap_min_reg  <= 8'd0;
    end else if (clear_p) begin
      lap_hold_reg <= 1'b0;
    end else if (lap_p && (state_reg == RUN)) begin
      if (lap_hold_reg) begin
        lap_hold_reg <= 1'b0;
      end else begin
        lap_hold_reg <= 1'b1;
        lap_sec_reg  <= sec_reg;
        lap_min_reg  <= min_reg;
      end
    end
  end

  assign lap_hold = lap_hold_reg;
  assign sec_out  = lap_hold_reg ? lap_sec_reg : sec_reg;
  assign min_out  = lap_hold_reg ? lap_min_reg : min_reg;
`else
  assign sec_out = sec_reg;
  assign min_out = min_reg;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter at TICK_DIV=4; define STOPWATCH_LAP_EN to cover the lap feature.
// Keys are driven 1 ns after a rising edge and outputs are sampled at the same offset.
module tb_stopwatch_counter;

  logic       clk;
  logic       rst_n;
  logic       key_start_n;
  logic       key_clear_n;
  logic [7:0] sec_out;
  logic [7:0] min_out;
  logic       running;
  logic       rollover;
`ifdef STOPWATCH_LAP_EN
  logic       key_lap_n;
  logic       lap_hold;
`endif

  int total_cnt = 0;
  int bad_cnt   = 0;

  stopwatch_counter #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_start_n (key_start_n),
    .key_clear_n (key_clear_n),
`ifdef STOPWATCH_LAP_EN
    .key_lap_n   (key_lap_n),
    .lap_hold    (lap_hold),
`endif
    .sec_out     (sec_out),
    .min_out     (min_out),
    .running     (running),
    .rollover    (rollover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
`ifdef STOPWATCH_LAP_EN
    key_lap_n   = 1'b1;
`endif
    step(2);
    check_val("rst_sec", {24'd0, sec_out}, 32'd0);
    check_val("rst_min", {24'd0, min_out}, 32'd0);
    check_val("rst_running", {31'd0, running}, 32'd0);
    check_val("rst_rollover", {31'd0, rollover}, 32'd0);
    rst_n = 1'b1;
    step(3);
    check_val("rel_no_start", {31'd0, running}, 32'd0);

    // Start, then 12 cycles = 3 seconds.
    key_start_n = 1'b0;
    step(3);
    key_start_n = 1'b1;
    check_val("start_running", {31'd0, running}, 32'd1);
    step(12);
    check_val("run12_sec", {24'd0, sec_out}, 32'd3);
    check_val("run12_min", {24'd0, min_out}, 32'd0);

    // Minute carry and full-hour rollover.
    step(224);
    check_val("at_0059_sec", {24'd0, sec_out}, 32'd59);
    step(4);
    check_val("at_0100_sec", {24'd0, sec_out}, 32'd0);
    check_val("at_0100_min", {24'd0, min_out}, 32'd1);
    step(14156);
    check_val("at_5959_sec", {24'd0, sec_out}, 32'd59);
    check_val("at_5959_min", {24'd0, min_out}, 32'd59);
    step(3);
    check_val("pre_wrap_rollover", {31'd0, rollover}, 32'd0);
    step(1);
    check_val("wrap_sec", {24'd0, sec_out}, 32'd0);
    check_val("wrap_min", {24'd0, min_out}, 32'd0);
    check_val("wrap_rollover", {31'd0, rollover}, 32'd1);
    step(1);
    check_val("post_wrap_rollover", {31'd0, rollover}, 32'd0);
    check_val("post_wrap_running", {31'd0, running}, 32'd1);

    key_clear_n = 1'b0;
    step(3);
    key_clear_n = 1'b1;
    check_val("clear_running", {31'd0, running}, 32'd0);
    check_val("clear_sec", {24'd0, sec_out}, 32'd0);
    step(3);

    // Pause with prescaler at 2, hold 40 cycles, resume.
    key_start_n = 1'b0;
    step(3);
    key_start_n = 1'b1;
    step(3);
    key_start_n = 1'b0;
    step(3);
    key_start_n = 1'b1;
    check_val("pause_running", {31'd0, running}, 32'd0);
    check_val("pause_sec", {24'd0, sec_out}, 32'd1);
    step(40);
    check_val("pause40_sec", {24'd0, sec_out}, 32'd1);
    check_val("pause40_running", {31'd0, running}, 32'd0);
    key_start_n = 1'b0;
    step(3);
    key_start_n = 1'b1;
    check_val("resume_running", {31'd0, running}, 32'd1);
    step(1);
    check_val("resume_c1_sec", {24'd0, sec_out}, 32'd1);
    step(1);
    check_val("resume_c2_sec", {24'd0, sec_out}, 32'd2);

    // Start and clear on the same sample edge: clear wins.
    key_start_n = 1'b0;
    key_clear_n = 1'b0;
    step(3);
    key_start_n = 1'b1;
    key_clear_n = 1'b1;
    check_val("both_running", {31'd0, running}, 32'd0);
    check_val("both_sec", {24'd0, sec_out}, 32'd0);
    check_val("both_min", {24'd0, min_out}, 32'd0);
    step(3);
    check_val("both_after_running", {31'd0, running}, 32'd0);

    // Held start key: one transition only.
    key_start_n = 1'b0;
    step(100);
    check_val("held_running", {31'd0, running}, 32'd1);
    check_val("held_sec", {24'd0, sec_out}, 32'd24);
    key_start_n = 1'b1;
    step(3);
    step(1704);
    check_val("at_0731_min", {24'd0, min_out}, 32'd7);
    check_val("at_0731_sec", {24'd0, sec_out}, 32'd31);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check_val("midrst_sec", {24'd0, sec_out}, 32'd0);
    check_val("midrst_min", {24'd0, min_out}, 32'd0);
    check_val("midrst_running", {31'd0, running}, 32'd0);
    step(5);
    check_val("midrst_idle", {31'd0, running}, 32'd0);
    check_val("midrst_sec_hold", {24'd0, sec_out}, 32'd0);

`ifdef STOPWATCH_LAP_EN
    // Lap in IDLE is ignored.
    key_lap_n = 1'b0;
    step(3);
    key_lap_n = 1'b1;
    step(3);
    check_val("lap_idle_hold", {31'd0, lap_hold}, 32'd0);
    key_start_n = 1'b0;
    step(3);
    key_start_n = 1'b1;
    step(18);
    key_lap_n = 1'b0;
    step(3);
    key_lap_n = 1'b1;
    check_val("lap1_hold", {31'd0, lap_hold}, 32'd1);
    check_val("lap1_sec", {24'd0, sec_out}, 32'd5);
    step(5);
    check_val("lap1_frozen_sec", {24'd0, sec_out}, 32'd5);
    check_val("lap1_frozen_min", {24'd0, min_out}, 32'd0);
    key_lap_n = 1'b0;
    step(3);
    key_lap_n = 1'b1;
    check_val("lap2_hold", {31'd0, lap_hold}, 32'd0);
    check_val("lap2_sec", {24'd0, sec_out}, 32'd7);
    step(3);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
